// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that gives NREQ requesters turns at one shared WIDTH-bit JK register bank.
// Optional macro JKARB_LOCK_EN lets a locking winner chain up to LOCK_MAX back-to-back operations.
module jk_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_j,
    input  logic [NREQ*WIDTH-1:0] op_k,
    input  logic [NREQ-1:0]       lock,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      q,
    output logic                  busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        RESP
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   last_q;
    logic [IDXW-1:0]   winner_q;
    logic [WIDTH-1:0]  j_lat_q;
    logic [WIDTH-1:0]  k_lat_q;
    logic [WIDTH-1:0]  q_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic              busy_q;

    logic [IDXW-1:0]   pick_d;
    logic              pick_vld_d;
    logic [WIDTH-1:0]  q_d;

`ifdef JKARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX + 1);
    logic [LCW-1:0] lock_cnt_q;
    logic           chain_d;

    assign chain_d = lock[winner_q] && req[winner_q] && (int'(lock_cnt_q) < LOCK_MAX - 1);
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // Search starts just past the previous winner and wraps, so the first hit is the fair choice.
    always_comb begin
        pick_d     = last_q;
        pick_vld_d = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!pick_vld_d && req[(int'(last_q) + off) % NREQ]) begin
                pick_vld_d = 1'b1;
                pick_d     = IDXW'((int'(last_q) + off) % NREQ);
            end
        end
    end

    // Per bit: J sets a clear bit, a set bit survives unless K; J&K therefore toggles.
    assign q_d = (j_lat_q & ~q_q) | (~k_lat_q & q_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the bank and the latched command are reset with the control state so an aborted op leaves nothing behind.
            state_q  <= IDLE;
            last_q   <= IDXW'(NREQ - 1);
            winner_q <= '0;
            j_lat_q  <= '0;
            k_lat_q  <= '0;
            q_q      <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
`ifdef JKARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= '0;
                    if (pick_vld_d) begin
                        winner_q <= pick_d;
                        j_lat_q  <= op_j[int'(pick_d)*WIDTH +: WIDTH];
                        k_lat_q  <= op_k[int'(pick_d)*WIDTH +: WIDTH];
                        gnt_q    <= NREQ'(1) << pick_d;
                        busy_q   <= 1'b1;
                        state_q  <= APPLY;
                    end else begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                APPLY: begin
                    q_q     <= q_d;
                    done_q  <= NREQ'(1) << winner_q;
                    state_q <= RESP;
                end
                RESP: begin
                    done_q <= '0;
                    last_q <= winner_q;
`ifdef JKARB_LOCK_EN
                    if (chain_d) begin
                        j_lat_q    <= op_j[int'(winner_q)*WIDTH +: WIDTH];
                        k_lat_q    <= op_k[int'(winner_q)*WIDTH +: WIDTH];
                        lock_cnt_q <= lock_cnt_q + LCW'(1);
                        state_q    <= APPLY;
                    end else begin
                        lock_cnt_q <= '0;
                        gnt_q      <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
`else
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign q    = q_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: directed plan steps plus randomized traffic
// compared against a transaction-level model of the arbitration and JK rules.
module tb_jk_bank_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int LOCK_MAX = 4;
`ifdef JKARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_j;
    logic [NREQ*WIDTH-1:0] op_k;
    logic [NREQ-1:0]       lock;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      q;
    logic                  busy;

    jk_bank_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .op_j(op_j), .op_k(op_k),
        .lock(lock), .gnt(gnt), .done(done), .q(q), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] jv [NREQ];
    logic [WIDTH-1:0] kv [NREQ];

    // Transaction-level model state.
    logic [WIDTH-1:0] q_m;
    int               last_m;
    int               cnt_m;
    bit               cont_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] jk_ref(input logic [WIDTH-1:0] qv,
                                                input logic [WIDTH-1:0] j,
                                                input logic [WIDTH-1:0] k);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) begin
            case ({j[b], k[b]})
                2'b00:   r[b] = qv[b];
                2'b01:   r[b] = 1'b0;
                2'b10:   r[b] = 1'b1;
                default: r[b] = ~qv[b];
            endcase
        end
        return r;
    endfunction

    function automatic int rr_ref(input logic [NREQ-1:0] r, input int last);
        for (int off = 1; off <= NREQ; off++) begin
            if (r[(last + off) % NREQ]) return (last + off) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_j[i*WIDTH +: WIDTH] = jv[i];
            op_k[i*WIDTH +: WIDTH] = kv[i];
        end
    endtask

    task automatic model_reset();
        q_m    = '0;
        last_m = NREQ - 1;
        cnt_m  = 0;
        cont_m = 1'b0;
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_q"},    q,    32'(q_m));
        check({tag, "_gnt"},  gnt,  32'h0);
        check({tag, "_busy"}, busy, 32'h0);
        check({tag, "_done"}, done, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            idle_checks("reset");
        end
        reset = 1'b1;
    endtask

    // Called on a falling edge where the next rising edge starts (or chains) an operation.
    task automatic serve(input bit drop, input bit corrupt, output int w);
        logic [WIDTH-1:0] js, ks;
        w  = cont_m ? last_m : rr_ref(req, last_m);
        js = jv[w];
        ks = kv[w];
        @(negedge clk);
        check("apply_gnt",  gnt,  32'(onehot(w)));
        check("apply_busy", busy, 32'h1);
        check("apply_done", done, 32'h0);
        check("apply_q",    q,    32'(q_m));
        if (corrupt) begin
            jv[w] = ~jv[w];
            drive_ops();
        end
        q_m = jk_ref(q_m, js, ks);
        @(negedge clk);
        check("resp_done", done, 32'(onehot(w)));
        check("resp_q",    q,    32'(q_m));
        check("resp_gnt",  gnt,  32'(onehot(w)));
        check("resp_busy", busy, 32'h1);
        if (drop) req[w] = 1'b0;
        last_m = w;
        if (LOCK_EN && lock[w] && req[w] && cnt_m < LOCK_MAX - 1) begin
            cnt_m++;
            cont_m = 1'b1;
        end else begin
            cnt_m  = 0;
            cont_m = 1'b0;
        end
        if (!cont_m) begin
            @(negedge clk);
            idle_checks("post");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        for (int i = 0; i < NREQ; i++) begin
            jv[i] = '0;
            kv[i] = '0;
        end
        drive_ops();

        do_reset();
        repeat (5) begin
            @(negedge clk);
            idle_checks("idle");
        end

        jv[1] = 8'hF0; kv[1] = 8'h00; drive_ops(); req = 4'b0010;
        serve(1'b1, 1'b0, w);
        check("single_set_q", q, 32'hF0);
        jv[1] = 8'hFF; kv[1] = 8'hFF; drive_ops(); req = 4'b0010;
        serve(1'b1, 1'b0, w);
        check("single_toggle_q", q, 32'h0F);
        jv[1] = 8'h00; kv[1] = 8'h0F; drive_ops(); req = 4'b0010;
        serve(1'b1, 1'b0, w);
        check("single_clear_q", q, 32'h00);

        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            jv[i] = WIDTH'(1 << i);
            kv[i] = '0;
        end
        drive_ops();
        req = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            serve(1'b0, 1'b0, w);
            check("rr_order", gnt, 32'h0);
        end
        check("rr_q", q, 32'h0F);
        serve(1'b0, 1'b0, w);
        req = '0;

        jv[1] = 8'h00; kv[1] = 8'hFF; drive_ops(); req = 4'b0010;
        serve(1'b1, 1'b0, w);
        jv[2] = 8'h01; kv[2] = 8'h00; drive_ops(); req = 4'b0100;
        serve(1'b1, 1'b1, w);
        check("late_q", q, 32'h01);

        jv[1] = 8'hAA; kv[1] = 8'h55; drive_ops(); req = 4'b0010;
        serve(1'b1, 1'b0, w);
        check("pre_reset_q", q, 32'hAA);
        jv[0] = 8'hFF; kv[0] = 8'hFF; drive_ops(); req = 4'b0001;
        @(negedge clk);
        check("mid_gnt", gnt, 32'h1);
        reset = 1'b0;
        req   = 4'b1000;
        #1;
        model_reset();
        idle_checks("mid_reset");
        @(negedge clk);
        idle_checks("mid_hold");
        reset = 1'b1;
        serve(1'b1, 1'b0, w);
        check("after_reset_q", q, 32'(jk_ref(8'h00, jv[3], kv[3])));

        do_reset();
        jv[0] = 8'hFF; kv[0] = 8'hFF;
        jv[1] = 8'h10; kv[1] = 8'h00;
        drive_ops();
        lock = 4'b0001;
        req  = 4'b0011;
        repeat (5) serve(1'b0, 1'b0, w);
        req  = '0;
        lock = '0;

        repeat (150) begin
            if (!cont_m) begin
                req  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                lock = NREQ'($urandom);
                for (int i = 0; i < NREQ; i++) begin
                    jv[i] = WIDTH'($urandom);
                    kv[i] = WIDTH'($urandom);
                end
                drive_ops();
            end
            serve(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end
        if (cont_m) serve(1'b1, 1'b0, w);
        req = '0;
        @(negedge clk);
        idle_checks("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
